// File: rtl/ham_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ham_rx_if
// Description : Bundles the serial codeword input stream and the decoded
//               result stream of the Hamming (17,12) receiver.
//               master : link source / result sink (drives rx_*, out_ready)
//               slave  : the receiver (drives rx_ready, out_*)
// Ports       : rx_bit, rx_valid, rx_sof, rx_ready   - serial bit stream
//               out_bits, out_syn, out_corr, out_uncorr,
//               out_valid, out_ready                 - decoded result
// Revision    : 1.0 - initial release
// ============================================================================
interface ham_rx_if;
    logic        rx_bit;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_ready;
    logic [11:0] out_bits;
    logic [4:0]  out_syn;
    logic        out_corr;
    logic        out_uncorr;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output rx_bit, rx_valid, rx_sof, out_ready,
        input  rx_ready, out_bits, out_syn, out_corr, out_uncorr, out_valid
    );

    modport slave (
        input  rx_bit, rx_valid, rx_sof, out_ready,
        output rx_ready, out_bits, out_syn, out_corr, out_uncorr, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/ham_rx.sv
`default_nettype none
// ============================================================================
// Module      : ham_rx
// Description : Serial Hamming (17,12) receiver. Deserialises a 17-bit
//               codeword (codeword[0] first, framed by rx_sof), decodes it
//               with single-error correction and presents the 12 info bits
//               on a valid/ready output register. Saturating codeword and
//               error counters track link quality.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               bus       - ham_rx_if.slave (bit stream in, result out)
//               cw_cnt    - codewords decoded (saturating)
//               err_cnt   - codewords with nonzero syndrome (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module ham_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    ham_rx_if.slave          bus,
    output logic [CNT_W-1:0] cw_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [4:0]       c_LAST_IDX = 5'd16;
    localparam logic [4:0]       c_MAX_POS  = 5'd17;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    // Deserialiser state
    logic [16:0]      sr_q,        sr_d;
    logic [4:0]       bcnt_q,      bcnt_d;
    logic             cw_full_q,   cw_full_d;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [11:0]      out_bits_q,  out_bits_d;
    logic [4:0]       out_syn_q,   out_syn_d;
    logic             out_corr_q,  out_corr_d;
    logic             out_uncorr_q, out_uncorr_d;

    // Statistics
    logic [CNT_W-1:0] cw_cnt_q,    cw_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;

    // Decoder
    logic [4:0]       w_syn;
    logic             w_corr;
    logic             w_uncorr;
    logic [16:0]      w_fixed;
    logic [11:0]      w_data;

    logic             w_accept;
    logic             w_xfer;

    assign w_accept = bus.rx_valid && !cw_full_q;
    // The output slot is free when empty or being drained on this same edge.
    assign w_xfer   = cw_full_q && (!out_valid_q || bus.out_ready);

    // Syndrome: XOR of the position numbers of all set bits, which is the
    // same as computing each syndrome bit over the positions having it set.
    always_comb begin
        w_syn = 5'd0;
        for (int p = 1; p <= 17; p++) begin
            if (sr_q[p-1]) begin
                w_syn = w_syn ^ 5'(p);
            end
        end
    end

    assign w_corr   = (w_syn != 5'd0) && (w_syn <= c_MAX_POS);
    assign w_uncorr = (w_syn > c_MAX_POS);

    always_comb begin
        w_fixed = sr_q;
        if (w_corr) begin
            w_fixed[w_syn - 5'd1] = ~sr_q[w_syn - 5'd1];
        end
    end

    // Info bits d0..d11 live at positions 3,5,6,7,9..15,17.
    assign w_data = {w_fixed[16], w_fixed[14:8], w_fixed[6:4], w_fixed[2]};

    always_comb begin
        sr_d         = sr_q;
        bcnt_d       = bcnt_q;
        cw_full_d    = cw_full_q;
        out_valid_d  = out_valid_q;
        out_bits_d   = out_bits_q;
        out_syn_d    = out_syn_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        cw_cnt_d     = cw_cnt_q;
        err_cnt_d    = err_cnt_q;

        // Output side: a transfer refills the slot, otherwise a completed
        // handshake empties it.
        if (w_xfer) begin
            cw_full_d    = 1'b0;
            out_valid_d  = 1'b1;
            out_bits_d   = w_data;
            out_syn_d    = w_syn;
            out_corr_d   = w_corr;
            out_uncorr_d = w_uncorr;
            if (cw_cnt_q != c_CNT_MAX) begin
                cw_cnt_d = cw_cnt_q + 1'b1;
            end
            if ((w_syn != 5'd0) && (err_cnt_q != c_CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        // Input side: accept only ever happens while cw_full is clear, so it
        // never collides with the transfer clearing it.
        if (w_accept) begin
            if (bus.rx_sof) begin
                // Start of frame always resynchronises, dropping any partial.
                sr_d[0] = bus.rx_bit;
                bcnt_d  = 5'd1;
            end else if (bcnt_q != 5'd0) begin
                sr_d[bcnt_q] = bus.rx_bit;
                if (bcnt_q == c_LAST_IDX) begin
                    bcnt_d    = 5'd0;
                    cw_full_d = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q         <= '0;
            bcnt_q       <= '0;
            cw_full_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            out_syn_q    <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            cw_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            sr_q         <= sr_d;
            bcnt_q       <= bcnt_d;
            cw_full_q    <= cw_full_d;
            out_valid_q  <= out_valid_d;
            out_bits_q   <= out_bits_d;
            out_syn_q    <= out_syn_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            cw_cnt_q     <= cw_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.rx_ready   = !cw_full_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_bits   = out_bits_q;
    assign bus.out_syn    = out_syn_q;
    assign bus.out_corr   = out_corr_q;
    assign bus.out_uncorr = out_uncorr_q;
    assign cw_cnt         = cw_cnt_q;
    assign err_cnt        = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ham_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ham_rx
// Description : Self-checking bench for ham_rx. Directed codewords are sent
//               serially; each expected result is queued when its frame is
//               issued and a monitor pops/compares on every output handshake.
//               A second instance with 2-bit counters shadows the traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ham_rx;

    typedef struct packed {
        logic [11:0] bits;
        logic [4:0]  syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] cw_cnt;
    logic [7:0] err_cnt;
    logic [1:0] cw_cnt2;
    logic [1:0] err_cnt2;

    int   checks;
    int   errors;
    int   exp_cw;
    int   exp_err;
    exp_t exp_q[$];

    ham_rx_if bus ();
    ham_rx_if bus2 ();

    ham_rx #(.CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cw_cnt  (cw_cnt),
        .err_cnt (err_cnt)
    );

    // Saturation shadow: sees the same bit stream, never backpressured.
    assign bus2.rx_bit    = bus.rx_bit;
    assign bus2.rx_valid  = bus.rx_valid;
    assign bus2.rx_sof    = bus.rx_sof;
    assign bus2.out_ready = 1'b1;

    ham_rx #(.CNT_W(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .cw_cnt  (cw_cnt2),
        .err_cnt (err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: outputs and out_ready are stable at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got bits %0h syn %0h, expected none",
                         bus.out_bits, bus.out_syn);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_bits",   32'(bus.out_bits),   32'(e.bits));
                check("out_syn",    32'(bus.out_syn),    32'(e.syn));
                check("out_corr",   32'(bus.out_corr),   32'(e.corr));
                check("out_uncorr", 32'(bus.out_uncorr), 32'(e.uncorr));
            end
        end
    end

    // Present a bit at the falling edge, hold until the receiver is ready,
    // and return right after the rising edge that accepts it.
    task automatic send_bit(input logic b, input logic sof);
        int n;
        @(negedge clk);
        bus.rx_bit   = b;
        bus.rx_valid = 1'b1;
        bus.rx_sof   = sof;
        n = 0;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout: got rx_ready 0, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [16:0] cw, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(cw[i], (i == 0));
        end
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_sof   = 1'b0;
    endtask

    task automatic push(input logic [11:0] b, input logic [4:0] s, input logic c, input logic u);
        exp_t e;
        e.bits = b; e.syn = s; e.corr = c; e.uncorr = u;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: got %0d pending, expected 0", name, exp_q.size());
        end
        check({name, "_cw_cnt"},  32'(cw_cnt),  32'(exp_cw));
        check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cw        = 0;
        exp_err       = 0;
        clk           = 1'b0;
        rst           = 1'b1;
        bus.rx_bit    = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_sof    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",   32'(bus.rx_ready),   32'd1);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_bits",   32'(bus.out_bits),   32'd0);
        check("rst_out_syn",    32'(bus.out_syn),    32'd0);
        check("rst_out_corr",   32'(bus.out_corr),   32'd0);
        check("rst_out_uncorr", 32'(bus.out_uncorr), 32'd0);
        check("rst_cw_cnt",     32'(cw_cnt),         32'd0);
        check("rst_err_cnt",    32'(err_cnt),        32'd0);
        rst = 1'b0;

        // Error-free codeword plus latency of the first result
        push(12'h0AF, 5'd0, 1'b0, 1'b0);
        exp_cw++;
        send_frame(17'h00A75, 17);
        #1;
        check("lat_valid_after_last", 32'(bus.out_valid), 32'd0);
        check("lat_rx_ready_drop",    32'(bus.rx_ready),  32'd0);
        @(posedge clk);
        #1;
        check("lat_valid_2cyc",       32'(bus.out_valid), 32'd1);
        wait_drain("clean");

        // Single data-bit error at position 7
        push(12'h0AF, 5'd7, 1'b1, 1'b0);
        exp_cw++; exp_err++;
        send_frame(17'h00A35, 17);
        wait_drain("data_err");

        // Parity-bit error at position 16
        push(12'h0AF, 5'd16, 1'b1, 1'b0);
        exp_cw++; exp_err++;
        send_frame(17'h08A75, 17);
        wait_drain("par_err");
        check("sat_err_cnt_2", 32'(err_cnt2), 32'd2);
        check("sat_cw_cnt_3",  32'(cw_cnt2),  32'd3);

        // Double error: syndrome 18 is out of range, data passes through
        push(12'h0AF, 5'd18, 1'b0, 1'b1);
        exp_cw++; exp_err++;
        send_frame(17'h08A77, 17);
        wait_drain("uncorr");

        // Backpressure: two frames with the sink stalled
        bus.out_ready = 1'b0;
        push(12'h0AF, 5'd0, 1'b0, 1'b0);
        push(12'h0AF, 5'd7, 1'b1, 1'b0);
        exp_cw += 2; exp_err++;
        send_frame(17'h00A75, 17);
        send_frame(17'h00A35, 17);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rx_ready",  32'(bus.rx_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_bits", 32'(bus.out_bits),  32'h0AF);
            check("bp_hold_syn",  32'(bus.out_syn),   32'd0);
        end
        bus.out_ready = 1'b1;
        wait_drain("backpressure");

        // Resync: 9 bits of a frame, then a fresh frame with rx_sof
        push(12'h0AF, 5'd0, 1'b0, 1'b0);
        exp_cw++;
        send_frame(17'h00A75, 9);
        send_frame(17'h00A75, 17);
        wait_drain("resync");

        // Bits before any rx_sof are ignored
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 1'b0);
        end
        #1;
        bus.rx_valid = 1'b0;
        push(12'h0AF, 5'd7, 1'b1, 1'b0);
        exp_cw++; exp_err++;
        send_frame(17'h00A35, 17);
        wait_drain("nosync");
        check("sat_err_cnt", 32'(err_cnt2), 32'd3);
        check("sat_cw_cnt",  32'(cw_cnt2),  32'd3);

        // Reset mid-frame, then a clean frame
        send_frame(17'h08A75, 8);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_bits",  32'(bus.out_bits),  32'd0);
        check("mid_rst_out_syn",   32'(bus.out_syn),   32'd0);
        check("mid_rst_out_corr",  32'(bus.out_corr),  32'd0);
        check("mid_rst_cw_cnt",    32'(cw_cnt),        32'd0);
        check("mid_rst_err_cnt",   32'(err_cnt),       32'd0);
        check("mid_rst_rx_ready",  32'(bus.rx_ready),  32'd1);
        rst = 1'b0;
        exp_cw  = 1;
        exp_err = 0;
        push(12'h0AF, 5'd0, 1'b0, 1'b0);
        send_frame(17'h00A75, 17);
        wait_drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ham_rx.md
# ham_rx

Serial Hamming (17,12) receiver: the far end of the link fed by the encoder. It deserialises a codeword bitstream and decodes each complete codeword with single-error correction. Each result is presented as 12 corrected info bits on a valid/ready output. Running codeword and error counters are kept for link-quality monitoring.

## Interface
- CNT_W, 8, width of the statistics counters `cw_cnt` and `err_cnt`.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_bit  in  1  serial codeword bit; `codeword[0]` is sent first.
- rx_valid  in  1  `rx_bit` is valid this cycle.
- rx_sof  in  1  start of frame; qualified by `rx_valid`, marks `codeword[0]`.
- rx_ready  out  1  receiver can accept a bit this cycle.
- out_bits  out  12  corrected info bits (esti_bits).
- out_syn  out  5  syndrome of the codeword.
- out_corr  out  1  a single error was corrected (syndrome 1..17).
- out_uncorr  out  1  syndrome 18..31; data passed through uncorrected.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts the result.
- cw_cnt  out  CNT_W  codewords decoded, saturating.
- err_cnt  out  CNT_W  codewords with a nonzero syndrome, saturating.

## Operation
- Code layout:
  - `codeword[i]` is Hamming position i+1.
  - Parity bits sit at positions 1, 2, 4, 8 and 16.
  - Info bits `d0..d11` fill positions 3, 5, 6, 7, 9..15 and 17, in that order.
  - Parity is even.
- Syndrome: bit k is the XOR of all positions whose index has bit k set.
  - syn = 0: data is passed unchanged.
  - syn = 1..17: invert position syn, then extract data; `out_corr` = 1.
  - syn = 18..31: extract data unchanged; `out_uncorr` = 1.
- Deserialiser: 17-bit shift register plus a 5-bit bit counter `bcnt` (0..16). A bit is accepted when `rx_valid && rx_ready`.
  - Accepted bit with `rx_sof` = 1: it is stored as bit 0 and `bcnt` = 1, regardless of prior `bcnt`. Any partial frame is discarded.
  - Accepted bit with `rx_sof` = 0 and `bcnt` = 0: the bit is ignored (no sync yet).
  - Otherwise the bit is stored at index `bcnt` and `bcnt` increments.
  - Acceptance of bit 16: `cw_full` is set and `bcnt` returns to 0.
- `rx_ready` = !`cw_full`.
- Transfer: on an edge where `cw_full` && (!`out_valid` || `out_ready`):
  - the decoder output loads into the output register and `out_valid` is set;
  - `cw_full` clears;
  - `cw_cnt` increments, and `err_cnt` increments if syn ≠ 0; both saturate at 2^CNT_W−1.
- Output handshake:
  - `out_valid && out_ready` with no transfer on the same edge clears `out_valid`.
  - While `out_valid` = 1 and `out_ready` = 0, all out_* signals hold stable.
- Reset: `bcnt`, `cw_full`, `out_valid`, `out_bits`, `out_syn`, `out_corr`, `out_uncorr`, `cw_cnt` and `err_cnt` all go to 0. `rx_ready` = 1 after reset. A partial or pending codeword is lost.

## Timing
- The edge that accepts bit 16 sets `cw_full`; `rx_ready` drops in the following cycle.
- Earliest result: `out_valid` is high one cycle after `cw_full`, i.e. 2 cycles after the last-bit edge.
- Sustained throughput is one codeword per 18 cycles: 17 bit cycles plus 1 transfer cycle.
- With `out_ready` held high, results issue back-to-back with no bubble.
- Backpressure: `cw_full` holds, and `rx_ready` stays 0, until the output slot frees. No bit is lost or overwritten.
- Decode is combinational from the shift register into the output register. There is no extra latency.

## Test plan
- Error-free codeword: send 17'h00A75 with `rx_sof` on bit 0 and `out_ready` = 1.
  - `out_bits` = 12'h0AF, `out_syn` = 0, `out_corr` = 0, `out_uncorr` = 0.
  - `out_valid` rises 2 cycles after the last bit; `cw_cnt` = 1, `err_cnt` = 0.
- Single data error: send 17'h00A35 (position 7 flipped).
  - `out_syn` = 7, `out_bits` = 12'h0AF, `out_corr` = 1, `err_cnt` increments.
- Parity-bit error: send 17'h08A75 (position 16 flipped).
  - `out_syn` = 16, `out_bits` = 12'h0AF, `out_corr` = 1.
- Uncorrectable: send 17'h08A77 (positions 2 and 16 flipped).
  - `out_syn` = 18, `out_uncorr` = 1, `out_corr` = 0, `out_bits` = 12'h0AF.
- Backpressure: hold `out_ready` = 0 and send two codewords, 17'h00A75 then 17'h00A35.
  - `rx_ready` drops after the second frame's last bit.
  - The first result holds stable.
  - Raising `out_ready` yields 0AF/syn 0 first, then 0AF/syn 7; no bits are dropped.
- Resync and reset:
  - After 9 bits of a frame, assert `rx_sof` with a fresh 17'h00A75. Exactly one result appears: 0AF/syn 0.
  - Bits sent before any `rx_sof` are ignored.
  - `rst` asserted mid-frame clears all outputs and counters to 0; the next full frame decodes correctly.
  - Counter saturation with CNT_W = 2: after 5 errored frames, `err_cnt` = 3.
